// File: rtl/spi_master_ctrl.sv
// Serial link initiator: shifts a command frame out on mosi under ss_n and, for
// read-data commands, captures the slave's reply from miso after a turnaround.
module spi_master_ctrl #(
  parameter int unsigned FRAME_W    = 10,
  parameter int unsigned RD_W       = 8,
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned IDLE_GAP   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [FRAME_W-1:0] cmd_data_i,
  output logic               ss_n_o,
  output logic               mosi_o,
  input  logic               miso_i,
  output logic               rd_valid_o,
  output logic [RD_W-1:0]    rd_data_o,
  output logic               busy_o
);

  localparam int unsigned Max1   = (FRAME_W > RD_W) ? FRAME_W : RD_W;
  localparam int unsigned Max2   = (Max1 > TURNAROUND) ? Max1 : TURNAROUND;
  localparam int unsigned CntMax = (Max2 > IDLE_GAP) ? Max2 : IDLE_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] LastBit  = CntW'(FRAME_W - 1);
  localparam logic [CntW-1:0] LastWait = CntW'(TURNAROUND - 1);
  localparam logic [CntW-1:0] LastRecv = CntW'(RD_W - 1);
  localparam logic [CntW-1:0] LastGap  = CntW'(IDLE_GAP - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StShift  = 3'd1;
  localparam logic [2:0] StWaitRd = 3'd2;
  localparam logic [2:0] StRecv   = 3'd3;
  localparam logic [2:0] StGap    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               is_rd_q, is_rd_d;
  logic [RD_W-2:0]    rx_q, rx_d;
  logic [RD_W-1:0]    rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [RD_W-1:0]    rx_full;

  // Reply so far including the bit being sampled on this edge.
  assign rx_full = {rx_q, miso_i};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    is_rd_d    = is_rd_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          shreg_d = cmd_data_i;
          is_rd_d = &cmd_data_i[FRAME_W-1:FRAME_W-2];
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = is_rd_q ? StWaitRd : StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitRd: begin
        if (cnt_q == LastWait) begin
          cnt_d   = '0;
          state_d = StRecv;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRecv: begin
        rx_d = rx_full[RD_W-2:0];
        if (cnt_q == LastRecv) begin
          rd_data_d  = rx_full;
          rd_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == LastGap) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      is_rd_q    <= 1'b0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      is_rd_q    <= is_rd_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Outputs decode straight from the state register so reset takes effect at its edge.
  always_comb begin
    cmd_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    ss_n_o      = !((state_q == StShift) || (state_q == StWaitRd) || (state_q == StRecv));
    mosi_o      = (state_q == StShift) & shreg_q[FRAME_W-1];
    rd_valid_o  = rd_valid_q;
    rd_data_o   = rd_data_q;
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: frame monitor and read-reply scoreboard
// compare against expectations queued when each command is issued.
module tb_spi_master_ctrl;

  localparam int TA   = 2;
  localparam int RDW  = 8;
  localparam int FW   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_data = '0;
  logic       ss_n;
  logic       mosi;
  logic       miso = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;

  typedef struct {
    logic [9:0] bits;
    int         low;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] rd_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         drop_next = 0;
  int         last_gap = 0;
  logic [7:0] slave_reply = 8'h00;

  spi_master_ctrl #(
    .FRAME_W   (FW),
    .RD_W      (RDW),
    .TURNAROUND(TA),
    .IDLE_GAP  (1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_data_i (cmd_data),
    .ss_n_o     (ss_n),
    .mosi_o     (mosi),
    .miso_i     (miso),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: drives the reply MSB first during the cycles the master samples it.
  initial begin
    int sidx;
    sidx = 0;
    forever begin
      @(negedge clk);
      if (ss_n == 1'b0) begin
        if (sidx >= FW + TA && sidx < FW + TA + RDW) miso = slave_reply[FW + TA + RDW - 1 - sidx];
        else miso = 1'b0;
        sidx++;
      end else begin
        sidx = 0;
        miso = 1'b0;
      end
    end
  end

  // Frame and read-reply monitor.
  initial begin
    bit         in_frame;
    int         low;
    int         high;
    logic [9:0] bits;
    frame_t     e;
    in_frame = 0;
    low = 0;
    high = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (ss_n == 1'b0) begin
        if (!in_frame) begin
          in_frame = 1;
          low = 0;
          bits = '0;
          last_gap = high;
          high = 0;
        end
        if (low < FW) bits = {bits[8:0], mosi};
        else chk("mosi_quiet_rx", {31'd0, mosi}, 32'd0);
        low++;
      end else begin
        chk("mosi_idle", {31'd0, mosi}, 32'd0);
        if (in_frame) begin
          in_frame = 0;
          if (drop_next) begin
            drop_next = 0;
          end else if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bits", {22'd0, bits}, {22'd0, e.bits});
            chk("frame_low", low, e.low);
          end
        end
        high++;
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("unexpected_rd_valid", 32'd1, 32'd0);
        else chk("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
      end
    end
  end

  // Queue expectations, raise cmd_valid and return just after the handshake edge.
  task automatic send(input logic [9:0] c, input bit expect_frame);
    int n;
    frame_t f;
    if (expect_frame) begin
      f.bits = c;
      f.low  = (c[9:8] == 2'b11) ? FW + TA + RDW : FW;
      exp_q.push_back(f);
      if (c[9:8] == 2'b11) rd_q.push_back(slave_reply);
    end
    cmd_data = c;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("handshake_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || !cmd_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ss_n", {31'd0, ss_n}, 32'd1);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write-addr frame; ready returns after SHIFT plus GAP
    send(10'h0A5, 1);
    cmd_valid = 1'b0;
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready || n > 100) break;
      n++;
    end
    chk("ready_return", n, FW + 1);
    wait_idle();

    // Read-data frame with reply C3, then another with 5A
    slave_reply = 8'hC3;
    send(10'h300, 1);
    cmd_valid = 1'b0;
    wait_idle();
    chk("rd_hold_c3", {24'd0, rd_data}, 32'h0C3);
    slave_reply = 8'h5A;
    send(10'h3E7, 1);
    cmd_valid = 1'b0;
    wait_idle();
    chk("rd_hold_5a", {24'd0, rd_data}, 32'h05A);

    // Read-addr frame leaves rd_data alone
    slave_reply = 8'hFF;
    send(10'h2AA, 1);
    cmd_valid = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("rd_after_rdaddr", {24'd0, rd_data}, 32'h05A);

    // Back-to-back writes with cmd_valid held high
    send(10'h1FF, 1);
    send(10'h000, 1);
    cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_gap", last_gap, 2);

    // Command inputs toggled while busy are ignored
    send(10'h1B4, 1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ready_low_busy", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 10'($urandom);
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);
    chk("no_extra_frames", exp_q.size(), 0);

    // Reset during bit 5 of a read-data frame
    slave_reply = 8'hA5;
    drop_next = 1;
    send(10'h3C5, 0);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_mosi", {31'd0, mosi}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ss_n", {31'd0, ss_n}, 32'd1);
    chk("abort_mosi", {31'd0, mosi}, 32'd0);
    chk("abort_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (30) @(negedge clk);
    chk("abort_no_rd", {24'd0, rd_data}, 32'd0);
    chk("abort_dropped", {31'd0, drop_next}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
